seq_adder_unit: RTL and testbench

//  Multi-cycle, parametrised add/sub unit for the NPC execute stage; next generation of the single-cycle adder.

---
 rtl/seq_adder_unit.sv | 193 +++++++++++++++++++
 tb/tb_seq_adder_unit.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/seq_adder_unit.sv
// Multi-cycle ripple-carry add/sub unit: WIDTH-bit operands summed CHUNK bits per cycle with valid/ready handshakes.
// Optional carry/overflow/zero flags are built only when ADDER_FLAGS_EN is defined; otherwise the flag ports read 0.
module seq_adder_unit #(
  parameter int WIDTH = 64,
  parameter int CHUNK = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] src1,
  input  logic [WIDTH-1:0] src2,
  input  logic [3:0]       control,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result_out,
  output logic             carry_out,
  output logic             ovf_out,
  output logic             zero_out
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  genvar gi;

  generate
    if (((WIDTH % CHUNK) != 0) || (WIDTH < 32)) begin : g_param_check
      $error("seq_adder_unit: WIDTH must be >= 32 and a multiple of CHUNK");
    end
  endgenerate

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t             state_reg, state_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic               carry_reg, carry_next;
  logic [WIDTH-1:0]   a_reg, a_next;
  logic [WIDTH-1:0]   b_reg, b_next;
  logic               w_reg, w_next;
  logic               align_reg, align_next;
  logic [WIDTH-1:0]   result_reg, result_next;

  logic [CHUNK-1:0]   a_chunk [NCHUNK];
  logic [CHUNK-1:0]   b_chunk [NCHUNK];
  logic [CHUNK:0]     chunk_sum;
  logic [WIDTH-1:0]   raw_sum;
  logic [WIDTH-1:0]   post_sum;
  logic               last_chunk;
  logic               busy_last;
  logic               is_sub;

  // raw_sum splices this cycle's chunk into the partial result so the final cycle sees the whole sum.
  generate
    for (gi = 0; gi < NCHUNK; gi++) begin : g_chunk
      assign a_chunk[gi] = a_reg[gi*CHUNK +: CHUNK];
      assign b_chunk[gi] = b_reg[gi*CHUNK +: CHUNK];
      assign raw_sum[gi*CHUNK +: CHUNK] = (cnt_reg == CNT_W'(gi)) ? chunk_sum[CHUNK-1:0]
                                                                  : result_reg[gi*CHUNK +: CHUNK];
    end
  endgenerate

  assign chunk_sum = {1'b0, a_chunk[cnt_reg]} + {1'b0, b_chunk[cnt_reg]} + {{CHUNK{1'b0}}, carry_reg};

  // Word modes sign-extend from bit 31; the align mode clears bit 0.
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_post
      if (gi == 0) begin : g_bit0
        assign post_sum[gi] = raw_sum[gi] & ~align_reg;
      end else if (gi >= 32) begin : g_upper
        assign post_sum[gi] = w_reg ? raw_sum[31] : raw_sum[gi];
      end else begin : g_lower
        assign post_sum[gi] = raw_sum[gi];
      end
    end
  endgenerate

  assign last_chunk = (cnt_reg == CNT_W'(NCHUNK - 1));
  assign busy_last  = (state_reg == ST_BUSY) && last_chunk && !flush;
  assign is_sub     = (control == 4'd1) || (control == 4'd3);

  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    carry_next  = carry_reg;
    a_next      = a_reg;
    b_next      = b_reg;
    w_next      = w_reg;
    align_next  = align_reg;
    result_next = result_reg;
    case (state_reg)
      ST_IDLE: begin
        if (in_valid && !flush) begin
          a_next     = src1;
          b_next     = is_sub ? ~src2 : src2;
          carry_next = is_sub;
          w_next     = (control == 4'd2) || (control == 4'd3);
          align_next = (control == 4'd4);
          cnt_next   = '0;
          state_next = ST_BUSY;
        end
      end
      ST_BUSY: begin
        result_next = last_chunk ? post_sum : raw_sum;
        carry_next  = chunk_sum[CHUNK];
        cnt_next    = cnt_reg + CNT_W'(1);
        if (last_chunk) begin
          state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
    if (flush) begin
      state_next = ST_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= ST_IDLE;
      cnt_reg    <= '0;
      carry_reg  <= 1'b0;
      a_reg      <= '0;
      b_reg      <= '0;
      w_reg      <= 1'b0;
      align_reg  <= 1'b0;
      result_reg <= '0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      carry_reg  <= carry_next;
      a_reg      <= a_next;
      b_reg      <= b_next;
      w_reg      <= w_next;
      align_reg  <= align_next;
      result_reg <= result_next;
    end
  end

  assign in_ready   = (state_reg == ST_IDLE);
  assign out_valid  = (state_reg == ST_DONE);
  assign result_out = result_reg;

`ifdef ADDER_FLAGS_EN
  logic carry_flag_reg, carry_flag_next;
  logic ovf_flag_reg, ovf_flag_next;
  logic zero_flag_reg, zero_flag_next;
  logic a_msb, b_msb, r_msb, cin_31, cout_31;

  // Carry out of bit 31 is recovered from the operand and sum bits, so no extra adder is needed.
  always_comb begin
    cin_31          = a_reg[31] ^ b_reg[31] ^ raw_sum[31];
    cout_31         = (a_reg[31] & b_reg[31]) | (cin_31 & (a_reg[31] ^ b_reg[31]));
    a_msb           = w_reg ? a_reg[31]   : a_reg[WIDTH-1];
    b_msb           = w_reg ? b_reg[31]   : b_reg[WIDTH-1];
    r_msb           = w_reg ? raw_sum[31] : raw_sum[WIDTH-1];
    carry_flag_next = w_reg ? cout_31 : chunk_sum[CHUNK];
    ovf_flag_next   = (a_msb == b_msb) && (r_msb != a_msb);
    zero_flag_next  = (post_sum == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      carry_flag_reg <= 1'b0;
      ovf_flag_reg   <= 1'b0;
      zero_flag_reg  <= 1'b0;
    end else if (busy_last) begin
      carry_flag_reg <= carry_flag_next;
      ovf_flag_reg   <= ovf_flag_next;
      zero_flag_reg  <= zero_flag_next;
    end
  end

  assign carry_out = carry_flag_reg;
  assign ovf_out   = ovf_flag_reg;
  assign zero_out  = zero_flag_reg;
`else
  assign carry_out = 1'b0;
  assign ovf_out   = 1'b0;
  assign zero_out  = 1'b0;
`endif

endmodule

// File: tb/tb_seq_adder_unit.sv
// Bench for seq_adder_unit (WIDTH=64, CHUNK=16): directed cases, reset/flush aborts and random ops
// checked against an arithmetic reference model; flag expectations follow ADDER_FLAGS_EN.
module tb_seq_adder_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] src1;
  logic [63:0] src2;
  logic [3:0]  control;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] result_out;
  logic        carry_out;
  logic        ovf_out;
  logic        zero_out;

  int vectors     = 0;
  int miscompares = 0;
  int op_idx      = 0;

  seq_adder_unit #(.WIDTH(64), .CHUNK(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .src1       (src1),
    .src2       (src2),
    .control    (control),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .result_out (result_out),
    .carry_out  (carry_out),
    .ovf_out    (ovf_out),
    .zero_out   (zero_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s op%0d: observed %h expected %h", tag, op_idx, obs, exp);
    end
  endtask

  // Reference: plain wide arithmetic on the operation's definition.
  function automatic void model(input logic [3:0] ctl, input logic [63:0] a, input logic [63:0] b,
                                output logic [63:0] r, output logic c, output logic v, output logic z);
    logic        sub, w;
    logic [63:0] bb;
    logic [32:0] s33;
    logic [64:0] s65;
    sub = (ctl == 4'd1) || (ctl == 4'd3);
    w   = (ctl == 4'd2) || (ctl == 4'd3);
    bb  = sub ? ~b : b;
    if (w) begin
      s33 = {1'b0, a[31:0]} + {1'b0, bb[31:0]} + 33'(sub);
      r   = {{32{s33[31]}}, s33[31:0]};
      c   = s33[32];
      v   = (a[31] == bb[31]) && (s33[31] != a[31]);
    end else begin
      s65 = {1'b0, a} + {1'b0, bb} + 65'(sub);
      r   = s65[63:0];
      c   = s65[64];
      v   = (a[63] == bb[63]) && (s65[63] != a[63]);
      if (ctl == 4'd4) r[0] = 1'b0;
    end
    z = (r == 64'd0);
  endfunction

  // Entered and left #1 after a rising edge with the unit idle.
  task automatic run_op(input logic [3:0] ctl, input logic [63:0] a, input logic [63:0] b, input int hold);
    logic [63:0] er;
    logic        ec, ev, ez;
    int          lat;
    bit          seen;
    op_idx++;
    model(ctl, a, b, er, ec, ev, ez);
`ifndef ADDER_FLAGS_EN
    ec = 1'b0; ev = 1'b0; ez = 1'b0;
`endif
    chk("in_ready_idle", 64'(in_ready), 64'd1);
    in_valid = 1'b1; src1 = a; src2 = b; control = ctl;
    @(posedge clk); #1;
    in_valid = 1'b0; src1 = {$urandom, $urandom}; src2 = {$urandom, $urandom}; control = 4'($urandom);
    chk("in_ready_busy", 64'(in_ready), 64'd0);
    lat = 1; seen = 0;
    while (lat <= 20 && !seen) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1; else lat++;
    end
    chk("latency", 64'(lat), 64'd4);
    for (int h = 0; h <= hold; h++) begin
      chk("out_valid", 64'(out_valid), 64'd1);
      chk("in_ready_done", 64'(in_ready), 64'd0);
      chk("result", result_out, er);
      chk("carry", 64'(carry_out), 64'(ec));
      chk("ovf", 64'(ovf_out), 64'(ev));
      chk("zero", 64'(zero_out), 64'(ez));
      if (h < hold) begin @(posedge clk); #1; end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("out_valid_drop", 64'(out_valid), 64'd0);
    chk("in_ready_back", 64'(in_ready), 64'd1);
    $display("op%0d ctl=%h a=%h b=%h -> exp %h c%0d v%0d z%0d", op_idx, ctl, a, b, er, ec, ev, ez);
  endtask

  task automatic pick_operand(output logic [63:0] x);
    case ($urandom_range(0, 3))
      0: x = {$urandom, $urandom};
      1: x = 64'hFFFF_FFFF_FFFF_FFFF;
      2: x = 64'h0000_0000_7FFF_FFFF;
      default: x = 64'($urandom_range(0, 15));
    endcase
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] ra, rb;
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    src1 = '0; src2 = '0; control = '0;
    #12;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_result", result_out, 64'd0);
    chk("rst_flags", {61'd0, carry_out, ovf_out, zero_out}, 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_op(4'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 0);
    run_op(4'd1, 64'd5, 64'd7, 0);
    run_op(4'd2, 64'h0000_0000_7FFF_FFFF, 64'd1, 0);
    run_op(4'd3, 64'd0, 64'd1, 0);
    run_op(4'd4, 64'h1001, 64'd4, 0);
    run_op(4'hF, 64'd2, 64'd3, 0);
    run_op(4'd1, 64'h8000_0000_0000_0000, 64'd1, 3);

    // Asynchronous reset during the second BUSY cycle.
    op_idx++;
    in_valid = 1'b1; src1 = 64'h1234; src2 = 64'h5678; control = 4'd0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_in_ready", 64'(in_ready), 64'd1);
    chk("arst_out_valid", 64'(out_valid), 64'd0);
    chk("arst_result", result_out, 64'd0);
    chk("arst_flags", {61'd0, carry_out, ovf_out, zero_out}, 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 6; i++) begin
      chk("arst_no_valid", 64'(out_valid), 64'd0);
      @(posedge clk); #1;
    end
    $display("op%0d reset mid-BUSY applied", op_idx);

    // Flush during BUSY, with a competing in_valid that must lose.
    op_idx++;
    in_valid = 1'b1; src1 = 64'd9; src2 = 64'd9; control = 4'd0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    flush = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      chk("flush_no_valid", 64'(out_valid), 64'd0);
      chk("flush_idle", 64'(in_ready), 64'd1);
      @(posedge clk); #1;
    end
    $display("op%0d flush in BUSY applied", op_idx);

    // Flush in DONE drops the pending result.
    op_idx++;
    in_valid = 1'b1; src1 = 64'd1; src2 = 64'd2; control = 4'd0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("done_before_flush", 64'(out_valid), 64'd1);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush_done_valid", 64'(out_valid), 64'd0);
    chk("flush_done_ready", 64'(in_ready), 64'd1);
    $display("op%0d flush in DONE applied", op_idx);

    for (int n = 0; n < 40; n++) begin
      pick_operand(ra);
      pick_operand(rb);
      run_op(4'($urandom_range(0, 15)), ra, rb, $urandom_range(0, 2));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
